// File: rtl/processor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : processor_pkg
//  Purpose  : Shared widths, instruction field positions, opcode constants
//             and a sign-extension helper for the accumulator processor.
//  Revision : 1.0  initial release
// ============================================================================
package processor_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 4;

  // Instruction field positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LUI  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BNZ  = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Sign-extend an 8-bit immediate to the data width
  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_rom.sv
`default_nettype none
// ============================================================================
//  Module   : program_rom
//  Purpose  : 16x16 combinational program store. The program counts result
//             upward by one per loop (ADD, OUT, JMP).
//  Revision : 1.0  initial release
// ============================================================================
module program_rom
  import processor_pkg::*;
(
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction
);

  // Address-to-instruction lookup; unlisted words are NOP
  always_comb begin
    case (address)
      4'd0:    instruction = 16'h1000; // LDI r0,0
      4'd1:    instruction = 16'h1401; // LDI r1,1
      4'd2:    instruction = 16'h3100; // ADD r0,r1
      4'd3:    instruction = 16'hE000; // OUT r0
      4'd4:    instruction = 16'hB002; // JMP 2
      default: instruction = 16'h0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/processor_core.sv
`default_nettype none
// ============================================================================
//  Module   : processor_core
//  Purpose  : Single-cycle 16-bit processor: 4-bit PC, four 16-bit general
//             registers and a registered OUT result word. Fetches one
//             instruction per clock from an external combinational ROM.
//  Options  : PROCESSOR_HALT_EN - opcode F sets a sticky halt flag that
//             freezes PC, registers and result until reset. Undefined:
//             opcode F is a NOP.
//  Revision : 1.0  initial release
// ============================================================================
module processor_core
  import processor_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] result
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en_d;
  logic [DATA_W-1:0] wr_data_d;
`ifdef PROCESSOR_HALT_EN
  logic              halt_q, halt_d;
`endif

  logic [3:0] opcode;
  logic [1:0] rd_idx;
  logic [1:0] rs_idx;
  logic [7:0] imm8;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;

  assign opcode = instruction[OPC_MSB:OPC_LSB];
  assign rd_idx = instruction[RD_MSB:RD_LSB];
  assign rs_idx = instruction[RS_MSB:RS_LSB];
  assign imm8   = instruction[IMM_MSB:IMM_LSB];

  // Operands come from the current register state, so rd == rs reads the old value
  assign rd_val = regs_q[rd_idx];
  assign rs_val = regs_q[rs_idx];

  assign address = pc_q;
  assign result  = result_q;

  // Decode and ALU: produce next PC, register write and next result
  always_comb begin
    pc_d      = pc_q + 4'd1;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    result_d  = result_q;
`ifdef PROCESSOR_HALT_EN
    halt_d    = halt_q;
`endif
    case (opcode)
      OP_NOP:  ;
      OP_LDI:  begin wr_en_d = 1'b1; wr_data_d = {8'h00, imm8}; end
      OP_LUI:  begin wr_en_d = 1'b1; wr_data_d = {imm8, rd_val[7:0]}; end
      OP_ADD:  begin wr_en_d = 1'b1; wr_data_d = rd_val + rs_val; end
      OP_SUB:  begin wr_en_d = 1'b1; wr_data_d = rd_val - rs_val; end
      OP_AND:  begin wr_en_d = 1'b1; wr_data_d = rd_val & rs_val; end
      OP_OR:   begin wr_en_d = 1'b1; wr_data_d = rd_val | rs_val; end
      OP_XOR:  begin wr_en_d = 1'b1; wr_data_d = rd_val ^ rs_val; end
      OP_SHL:  begin wr_en_d = 1'b1; wr_data_d = rd_val << imm8[3:0]; end
      OP_SHR:  begin wr_en_d = 1'b1; wr_data_d = rd_val >> imm8[3:0]; end
      OP_ADDI: begin wr_en_d = 1'b1; wr_data_d = rd_val + sext8(imm8); end
      OP_JMP:  pc_d = imm8[3:0];
      OP_BZ:   if (rd_val == '0) pc_d = imm8[3:0];
      OP_BNZ:  if (rd_val != '0) pc_d = imm8[3:0];
      OP_OUT:  result_d = rd_val;
      OP_HALT: begin
`ifdef PROCESSOR_HALT_EN
        halt_d = 1'b1;
`endif
      end
      default: ;
    endcase
`ifdef PROCESSOR_HALT_EN
    // Once halted, nothing may change until reset
    if (halt_q) begin
      pc_d     = pc_q;
      wr_en_d  = 1'b0;
      result_d = result_q;
      halt_d   = 1'b1;
    end
`endif
  end

  // Architectural state: PC, register file, result (and halt flag)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      result_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef PROCESSOR_HALT_EN
      halt_q   <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      result_q <= result_d;
      if (wr_en_d) regs_q[rd_idx] <= wr_data_d;
`ifdef PROCESSOR_HALT_EN
      halt_q   <= halt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_processor_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_processor_core
//  Purpose  : Directed self-checking bench for processor_core, driven either
//             by program_rom or by a bench-owned instruction table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_processor_core;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [3:0]  address;
  logic [15:0] result;
  logic [15:0] rom_instr;
  logic        use_rom;
  logic [15:0] prog [16];

  int n_checks;
  int n_errors;

  processor_core dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .address     (address),
    .result      (result)
  );

  program_rom rom (
    .address     (address),
    .instruction (rom_instr)
  );

  assign instruction = use_rom ? rom_instr : prog[address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
  endtask

  // Pulse reset between edges and release on the falling edge
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    use_rom  = 1'b1;
    reset    = 1'b1;
    clear_prog();

    // ROM program: reset state then counting loop
    #2;
    check_eq("rst_addr", {12'h0, address}, 16'h0000);
    check_eq("rst_result", result, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step(3);
    check_eq("rom_before_out", result, 16'h0000);
    step(1);
    check_eq("rom_out1", result, 16'h0001);
    step(1);
    check_eq("rom_jmp_addr", {12'h0, address}, 16'h0002);
    step(2);
    check_eq("rom_out2", result, 16'h0002);
    step(3);
    check_eq("rom_out3", result, 16'h0003);

    // Asynchronous reset between edges clears immediately
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_addr", {12'h0, address}, 16'h0000);
    check_eq("async_result", result, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step(4);
    check_eq("restart_out1", result, 16'h0001);

    use_rom = 1'b0;

    // Wrap: FFFF + 1 -> 0000
    clear_prog();
    prog[0] = 16'h10FF; prog[1] = 16'h20FF; prog[2] = 16'h1401;
    prog[3] = 16'hE000; prog[4] = 16'h3100; prog[5] = 16'hE000;
    do_reset();
    step(4);
    check_eq("wrap_ffff", result, 16'hFFFF);
    step(2);
    check_eq("wrap_zero", result, 16'h0000);

    // JMP 15 then NOP wraps PC to 0
    clear_prog();
    prog[0] = 16'hB00F;
    do_reset();
    step(1);
    check_eq("jmp15", {12'h0, address}, 16'h000F);
    step(1);
    check_eq("pc_wrap", {12'h0, address}, 16'h0000);

    // BZ r2,7 with r2 = 0 is taken
    clear_prog();
    prog[0] = 16'hC807;
    do_reset();
    step(1);
    check_eq("bz_taken", {12'h0, address}, 16'h0007);

    // BNZ r2,7 with r2 = 0 falls through
    clear_prog();
    prog[0] = 16'hD807;
    do_reset();
    step(1);
    check_eq("bnz_not_taken", {12'h0, address}, 16'h0001);

    // LDI/LUI/ADDI/SHR
    clear_prog();
    prog[0] = 16'h1034; prog[1] = 16'h2012; prog[2] = 16'hE000;
    prog[3] = 16'hA0FF; prog[4] = 16'hE000; prog[5] = 16'h9004;
    prog[6] = 16'hE000;
    do_reset();
    step(3);
    check_eq("ldi_lui", result, 16'h1234);
    step(2);
    check_eq("addi_neg", result, 16'h1233);
    step(2);
    check_eq("shr4", result, 16'h0123);

    // XOR/SUB/ADD rd==rs/AND/SHL/BNZ taken
    clear_prog();
    prog[0]  = 16'h140F; // LDI r1,0F
    prog[1]  = 16'h183C; // LDI r2,3C
    prog[2]  = 16'h7600; // XOR r1,r2 -> 0033
    prog[3]  = 16'hE400;
    prog[4]  = 16'h4600; // SUB r1,r2 -> FFF7
    prog[5]  = 16'hE400;
    prog[6]  = 16'h3A00; // ADD r2,r2 -> 0078
    prog[7]  = 16'hE800;
    prog[8]  = 16'h5900; // AND r2,r1 -> 0070
    prog[9]  = 16'h8808; // SHL r2,8  -> 7000
    prog[10] = 16'hE800;
    prog[11] = 16'hD80D; // BNZ r2,13 taken
    do_reset();
    step(4);
    check_eq("xor", result, 16'h0033);
    step(2);
    check_eq("sub_wrap", result, 16'hFFF7);
    step(2);
    check_eq("add_self", result, 16'h0078);
    step(3);
    check_eq("and_shl", result, 16'h7000);
    step(1);
    check_eq("bnz_taken", {12'h0, address}, 16'h000D);

    // HALT at address 5
    clear_prog();
    prog[0] = 16'h1405; prog[1] = 16'hE400; prog[5] = 16'hF000;
    prog[6] = 16'h1409; prog[7] = 16'hE400;
    do_reset();
    step(6);
    check_eq("halt_addr6", {12'h0, address}, 16'h0006);
    check_eq("pre_halt_result", result, 16'h0005);
    step(2);
`ifdef PROCESSOR_HALT_EN
    check_eq("halt_frozen_addr", {12'h0, address}, 16'h0006);
    check_eq("halt_hold_result", result, 16'h0005);
`else
    check_eq("nohalt_addr", {12'h0, address}, 16'h0008);
    check_eq("nohalt_result", result, 16'h0009);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
